// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Register-file read-out engine. A start pulse latches an index range,
//   the range is walked through the RF's spare combinational read port, and
//   each value is streamed over a valid/ready interface to a debug sink.
//   The range wraps modulo NUM_REGS, so first > last is legal.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset (0 = reset)
//   start        one-cycle dump request, honoured only in IDLE
//   abort        synchronous cancel, wins over everything except rst
//   dump_first   first register index, sampled with start
//   dump_last    last register index, sampled with start
//   rf_addr      RF read address
//   rf_data      RF read data, combinational from rf_addr
//   out_valid    out_data/out_idx/out_last are valid
//   out_ready    sink accepts the word when high with out_valid
//   out_data     register value (or checksum)
//   out_idx      index of out_data
//   out_last     final word of this dump
//   out_is_sum   checksum word marker (REG_DUMP_CHECKSUM_EN only)
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the last handshake
//
// Build option
//   REG_DUMP_CHECKSUM_EN : append an XOR checksum word after the last register.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// READ  | rf_addr driven, value/index captured at the clock edge
// SEND  | out_valid high, word held until handshake
// CSUM  | checksum word on the output (REG_DUMP_CHECKSUM_EN only)
// DONE  | one-cycle done pulse, start ignored

module reg_dump_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] dump_first,
  input  logic [ADDR_W-1:0] dump_last,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
`ifdef REG_DUMP_CHECKSUM_EN
  output logic              out_is_sum,
`endif
  output logic              busy,
  output logic              done
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

  state_t state, state_next;

  logic [ADDR_W-1:0] last_q;
  // Set in READ when the captured index is the final one of the range.
  logic              word_last;
  logic              hs;
  logic [ADDR_W-1:0] addr_inc;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  assign hs       = out_valid && out_ready;
  assign addr_inc = (rf_addr == ADDR_W'(NUM_REGS - 1)) ? '0 : rf_addr + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    done       = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    out_is_sum = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start && !abort) state_next = S_READ;
      end
      S_READ: begin
        busy       = 1'b1;
        state_next = abort ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        // The checksum word carries out_last, never the final register.
        out_last  = 1'b0;
`else
        out_last  = word_last;
`endif
        if (abort) begin
          state_next = S_IDLE;
        end else if (hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
          state_next = word_last ? S_CSUM : S_READ;
`else
          state_next = word_last ? S_DONE : S_READ;
`endif
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_last   = 1'b1;
        out_is_sum = 1'b1;
        if (abort)   state_next = S_IDLE;
        else if (hs) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        busy       = 1'b1;
        done       = !abort;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // rf_addr doubles as the current-index register: it is only advanced on a
  // non-final handshake, so it holds its value outside READ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_addr   <= '0;
      last_q    <= '0;
      word_last <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rf_addr <= dump_first;
            last_q  <= dump_last;
`ifdef REG_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        S_READ: begin
          out_data  <= rf_data;
          out_idx   <= rf_addr;
          word_last <= (rf_addr == last_q);
        end
        S_SEND: begin
          if (hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
            csum <= csum ^ out_data;
            if (word_last) begin
              out_data <= csum ^ out_data;
              out_idx  <= '0;
            end
`endif
            if (!word_last) rf_addr <= addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
module tb_reg_dump_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  dump_first;
  logic [4:0]  dump_last;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic        out_is_sum;
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic [31:0] rf_mem [32];
  assign rf_data = rf_mem[rf_addr];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_dump_unit #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dump_first (dump_first),
    .dump_last  (dump_last),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
`ifdef REG_DUMP_CHECKSUM_EN
    .out_is_sum (out_is_sum),
`endif
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  first;
    logic [4:0]  last;
    int          n;
    logic [31:0] d_first;
    logic [31:0] d_last;
  } vec_t;

  // Full dump with out_ready held high; checks every word, timing and counts.
  task automatic run_dump(input vec_t v);
    int words = 0, dones = 0, done_cyc = -1, busy_cyc = 0;
    int lim = 2 * v.n + EXTRA + 4;
    logic [31:0] xs = '0, g_first = '0, g_last = '0;
    logic [4:0]  ei;
    @(negedge clk);
    dump_first = v.first; dump_last = v.last; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rf_addr_cycle1", rf_addr, v.first);
    for (int cyc = 1; cyc <= lim; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (busy) busy_cyc++;
      if (out_valid) begin
        if (words < v.n) begin
          ei = v.first + 5'(words);
          chk("word_idx", out_idx, ei);
          chk("word_data", out_data, rf_mem[ei]);
`ifdef REG_DUMP_CHECKSUM_EN
          chk("word_last", out_last, 1'b0);
          chk("word_is_sum", out_is_sum, 1'b0);
`else
          chk("word_last", out_last, (words == v.n - 1));
`endif
          xs ^= rf_mem[ei];
          if (words == 0) g_first = out_data;
          if (words == v.n - 1) g_last = out_data;
        end
`ifdef REG_DUMP_CHECKSUM_EN
        else if (words == v.n) begin
          chk("sum_idx", out_idx, 5'd0);
          chk("sum_data", out_data, xs);
          chk("sum_last", out_last, 1'b1);
          chk("sum_is_sum", out_is_sum, 1'b1);
        end
`endif
        words++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
    chk("word_count", words, v.n + EXTRA);
    chk("done_count", dones, 1);
    chk("done_cycle", done_cyc, 2 * v.n + 1 + EXTRA);
    chk("busy_cycles", busy_cyc, 2 * v.n + 1 + EXTRA);
    chk("first_value", g_first, v.d_first);
    chk("last_value", g_last, v.d_last);
`ifndef REG_DUMP_CHECKSUM_EN
    chk("out_data_hold", out_data, v.d_last);
`endif
  endtask

  initial begin
    vec_t vecs [5];
    bit zero_ok, stable_ok, saw_valid;
    int dones;
    logic [31:0] hd;
    logic [4:0]  hi;
    logic        hl;

    vecs[0] = '{first: 5'd2,  last: 5'd5,  n: 4,  d_first: 32'd6,        d_last: 32'd15};
    vecs[1] = '{first: 5'd30, last: 5'd1,  n: 4,  d_first: 32'hFFFFFFF9, d_last: 32'd1};
    vecs[2] = '{first: 5'd4,  last: 5'd4,  n: 1,  d_first: 32'd12,       d_last: 32'd12};
    vecs[3] = '{first: 5'd0,  last: 5'd31, n: 32, d_first: 32'd0,        d_last: 32'd100};
    vecs[4] = '{first: 5'd7,  last: 5'd6,  n: 32, d_first: 32'd21,       d_last: 32'd18};

    for (int r = 0; r < 32; r++) rf_mem[r] = 32'(r * 3);
    rf_mem[30] = 32'hFFFFFFF9;
    rf_mem[31] = 32'd100;
    rf_mem[0]  = 32'd0;
    rf_mem[1]  = 32'd1;

    // Reset held for 100 ns while start toggles.
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    dump_first = 5'd0; dump_last = 5'd3;
    zero_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rf_addr !== 0 || out_valid !== 0 || out_data !== 0 || out_idx !== 0 ||
          out_last !== 0 || busy !== 0 || done !== 0) zero_ok = 1'b0;
      start = ~start;
    end
    chk("reset_outputs_zero", zero_ok, 1'b1);
    start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_valid", out_valid, 1'b0);

    for (int t = 0; t < 5; t++) run_dump(vecs[t]);

    // Backpressure: single word held for 10 cycles with out_ready low.
    @(negedge clk);
    dump_first = 5'd4; dump_last = 5'd4; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin saw_valid = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp_valid_seen", saw_valid, 1'b1);
    hd = out_data; hi = out_idx; hl = out_last;
    stable_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid !== 1'b1 || out_data !== hd || out_idx !== hi ||
          out_last !== hl || done !== 1'b0) stable_ok = 1'b0;
      @(negedge clk);
    end
    chk("bp_stable", stable_ok, 1'b1);
    chk("bp_data", hd, 32'd12);
    chk("bp_idx", hi, 5'd4);
    chk("bp_last", hl, (EXTRA == 0));
    out_ready = 1'b1;
    @(negedge clk);
`ifdef REG_DUMP_CHECKSUM_EN
    chk("bp_sum_word", out_is_sum, 1'b1);
    @(negedge clk);
`endif
    chk("bp_done", done, 1'b1);
    chk("bp_valid_after", out_valid, 1'b0);

    // Abort in the 2nd SEND of a 0..31 dump, with a start pulse mid-dump.
    @(negedge clk);
    dump_first = 5'd0; dump_last = 5'd31; start = 1'b1;
    @(negedge clk);                       // cycle 1: READ idx 0
    start = 1'b0;
    @(negedge clk);                       // cycle 2: SEND idx 0
    dump_first = 5'd9; start = 1'b1;
    @(negedge clk);                       // cycle 3: READ idx 1
    start = 1'b0;
    chk("ab_rf_addr_no_restart", rf_addr, 5'd1);
    @(negedge clk);                       // cycle 4: SEND idx 1
    chk("ab_second_send_valid", out_valid, 1'b1);
    chk("ab_second_send_idx", out_idx, 5'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid_cleared", out_valid, 1'b0);
    chk("ab_busy_cleared", busy, 1'b0);
    chk("ab_last_cleared", out_last, 1'b0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("ab_no_done", dones, 0);
    run_dump('{first: 5'd0, last: 5'd0, n: 1, d_first: 32'd0, d_last: 32'd0});

    // Abort together with start in IDLE: nothing starts.
    @(negedge clk);
    dump_first = 5'd3; dump_last = 5'd4; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);
    @(negedge clk);
    chk("idle_abort_busy2", busy, 1'b0);
    chk("idle_abort_valid", out_valid, 1'b0);

`ifdef REG_DUMP_CHECKSUM_EN
    rf_mem[1] = 32'h0F; rf_mem[2] = 32'hF0; rf_mem[3] = 32'hFF;
    run_dump('{first: 5'd1, last: 5'd3, n: 3, d_first: 32'h0F, d_last: 32'hFF});
    chk("csum_final_data", out_data, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
